// File: rtl/icb_sram_pipe.sv
// ICB-attached SRAM. The array is sampled at command accept; every response walks an
// RD_LAT-deep pipeline and drains in command order through an OUTS-deep response FIFO.
module icb_sram_pipe #(
  parameter int unsigned DW           = 32,
  parameter int unsigned MW           = DW / 8,
  parameter int unsigned AW           = 32,
  parameter int unsigned DP           = 131072,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned OUTS         = 2,
  parameter int unsigned FORCE_X2ZERO = 1
) (
  input  logic          hfclk,
  input  logic          hfclkrst,
  input  logic          i_icb_cmd_valid,
  output logic          i_icb_cmd_ready,
  input  logic          i_icb_cmd_read,
  input  logic [AW-1:0] i_icb_cmd_addr,
  input  logic [DW-1:0] i_icb_cmd_wdata,
  input  logic [MW-1:0] i_icb_cmd_wmask,
  output logic          i_icb_rsp_valid,
  input  logic          i_icb_rsp_ready,
  output logic          i_icb_rsp_err,
  output logic [DW-1:0] i_icb_rsp_rdata,
  output logic          busy
);

  localparam int unsigned MWL = $clog2(MW);
  localparam int unsigned DPL = $clog2(DP);
  localparam int unsigned CW  = $clog2(OUTS + 1);
  localparam int unsigned PW  = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int unsigned L   = RD_LAT - 1;

  logic [DW-1:0]     mem_q [DP];
  logic [AW-1:0]     word;
  logic [DPL-1:0]    widx;
  logic              cmd_oor, accept, rsp_fire, mem_we, push, pop, fifo_empty;

  logic [RD_LAT-1:0] pv_q, pv_d, perr_q, perr_d;
  logic [DW-1:0]     pdata_q [RD_LAT];
  logic [DW-1:0]     pdata_d [RD_LAT];

  logic [DW-1:0]     fdata_q [OUTS];
  logic [OUTS-1:0]   ferr_q;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d, inflight_q, inflight_d;
  logic [DW-1:0]     rdata_raw;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign word    = i_icb_cmd_addr >> MWL;
  assign widx    = word[DPL-1:0];
  assign cmd_oor = |(word >> DPL);

  // Ready comes only from registered occupancy, so it never loops through valid or rsp_ready.
  assign i_icb_cmd_ready = ~hfclkrst & (inflight_q < CW'(OUTS));
  assign accept          = i_icb_cmd_valid & i_icb_cmd_ready;
  assign mem_we          = accept & ~i_icb_cmd_read & ~cmd_oor;

  assign fifo_empty      = (fcnt_q == '0);
  assign i_icb_rsp_valid = ~fifo_empty | pv_q[L];
  assign rsp_fire        = i_icb_rsp_valid & i_icb_rsp_ready;
  assign pop             = ~fifo_empty & i_icb_rsp_ready;
  // The last stage bypasses an empty FIFO; anything not taken that cycle is parked in the FIFO.
  assign push            = pv_q[L] & ~(fifo_empty & i_icb_rsp_ready);
  assign busy            = (inflight_q != '0);

  always_comb begin
    pv_d   = '0;
    perr_d = '0;
    for (int i = 0; i < RD_LAT; i++) pdata_d[i] = '0;
    pv_d[0]    = accept;
    perr_d[0]  = cmd_oor;
    pdata_d[0] = (i_icb_cmd_read && !cmd_oor) ? mem_q[widx] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i]    = pv_q[i-1];
      perr_d[i]  = perr_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end
  end

  always_comb begin
    wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = pop ? ptr_inc(rptr_q) : rptr_q;
    fcnt_d     = fcnt_q;
    inflight_d = inflight_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    case ({accept, rsp_fire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    i_icb_rsp_err = 1'b0;
    rdata_raw     = '0;
    if (!fifo_empty) begin
      i_icb_rsp_err = ferr_q[rptr_q];
      rdata_raw     = fdata_q[rptr_q];
    end else if (pv_q[L]) begin
      i_icb_rsp_err = perr_q[L];
      rdata_raw     = pdata_q[L];
    end
  end

  // Unwritten words read back as X in 4-state simulation; collapsing X/Z to 0 is a plain
  // wire in hardware.
  always_comb begin
    i_icb_rsp_rdata = rdata_raw;
    if (FORCE_X2ZERO != 0) begin
      for (int i = 0; i < DW; i++) i_icb_rsp_rdata[i] = (rdata_raw[i] === 1'b1);
    end
  end

  always_ff @(posedge hfclk) begin
    if (hfclkrst) begin
      pv_q       <= '0;
      perr_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
      inflight_q <= '0;
    end else begin
      pv_q       <= pv_d;
      perr_q     <= perr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload storage and the array itself are never reset; validity lives in the flops above.
  always_ff @(posedge hfclk) begin
    for (int i = 0; i < RD_LAT; i++) pdata_q[i] <= pdata_d[i];
    if (push) begin
      fdata_q[wptr_q] <= pdata_q[L];
      ferr_q[wptr_q]  <= perr_q[L];
    end
    if (mem_we) begin
      for (int b = 0; b < MW; b++) begin
        if (i_icb_cmd_wmask[b]) mem_q[widx][8*b +: 8] <= i_icb_cmd_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_icb_sram_pipe.sv
// Bench for icb_sram_pipe: two instances (RD_LAT=1/OUTS=2 and RD_LAT=3/OUTS=4, DP=1024),
// directed commands push expected responses into per-instance queues checked by a monitor.
`timescale 1ns/1ps
module tb_icb_sram_pipe;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          at;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, cv, rd, rr, acc_q;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  wmask;
  wire  [1:0]       cr, rv, rerr, bsy;
  wire  [1:0][31:0] rdata;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] vals [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};

  icb_sram_pipe #(
    .DW(32), .MW(4), .AW(32), .DP(1024), .RD_LAT(1), .OUTS(2), .FORCE_X2ZERO(1)
  ) u_dut0 (
    .hfclk(clk), .hfclkrst(rst[0]),
    .i_icb_cmd_valid(cv[0]), .i_icb_cmd_ready(cr[0]), .i_icb_cmd_read(rd[0]),
    .i_icb_cmd_addr(addr[0]), .i_icb_cmd_wdata(wdata[0]), .i_icb_cmd_wmask(wmask[0]),
    .i_icb_rsp_valid(rv[0]), .i_icb_rsp_ready(rr[0]), .i_icb_rsp_err(rerr[0]),
    .i_icb_rsp_rdata(rdata[0]), .busy(bsy[0])
  );

  icb_sram_pipe #(
    .DW(32), .MW(4), .AW(32), .DP(1024), .RD_LAT(3), .OUTS(4), .FORCE_X2ZERO(1)
  ) u_dut1 (
    .hfclk(clk), .hfclkrst(rst[1]),
    .i_icb_cmd_valid(cv[1]), .i_icb_cmd_ready(cr[1]), .i_icb_cmd_read(rd[1]),
    .i_icb_cmd_addr(addr[1]), .i_icb_cmd_wdata(wdata[1]), .i_icb_cmd_wmask(wmask[1]),
    .i_icb_rsp_valid(rv[1]), .i_icb_rsp_ready(rr[1]), .i_icb_rsp_err(rerr[1]),
    .i_icb_rsp_rdata(rdata[1]), .busy(bsy[1])
  );

  // Handshake observed at each edge, plus a cycle counter for latency checks.
  always @(posedge clk) begin
    acc_q <= cv & cr;
    cyc   <= cyc + 1;
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL dut%0d stray response: got err=%0b rdata=0x%08h, want no response",
               d, rerr[d], rdata[d]);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("dut%0d %s err", d, e.name), 32'(rerr[d]), 32'(e.err));
    chk($sformatf("dut%0d %s rdata", d, e.name), rdata[d], e.data);
    if (e.at >= 0) chk($sformatf("dut%0d %s rsp cycle", d, e.name), 32'(cyc), 32'(e.at));
  endtask

  always @(negedge clk) begin
    if (rv[0] && rr[0] && !rst[0]) mon(0);
    if (rv[1] && rr[1] && !rst[1]) mon(1);
  end

  task automatic issue(input int d, input bit read, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m, input bit eerr,
                       input logic [31:0] edata, input bit timed, input string name,
                       output int acc);
    exp_t e;
    int   n;
    cv[d] = 1'b1; rd[d] = read; addr[d] = a; wdata[d] = wd; wmask[d] = m;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_q[d] && n < 40);
    cv[d] = 1'b0;
    acc   = cyc - 1;
    if (!acc_q[d]) begin
      checks++;
      failures++;
      $display("FAIL dut%0d %s accept: got none in 40 cycles, want accept", d, name);
      acc = -1;
      return;
    end
    e.err  = eerr;
    e.data = edata;
    e.at   = timed ? acc + lat(d) : -1;
    e.name = name;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drain(input int d, input string name);
    int n;
    n = 0;
    while ((bsy[d] || ((d == 0) ? q0.size() : q1.size()) != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d %s drained busy", d, name), 32'(bsy[d]), 32'd0);
    chk($sformatf("dut%0d %s drained queue", d, name),
        32'((d == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, t;
    int acc4 [4];
    rst = 2'b11; cv = '0; rd = '0; rr = 2'b11;
    addr = '0; wdata = '0; wmask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset cmd_ready", d), 32'(cr[d]), 32'd1);
      chk($sformatf("dut%0d reset rsp_valid", d), 32'(rv[d]), 32'd0);
      chk($sformatf("dut%0d reset rsp_err", d), 32'(rerr[d]), 32'd0);
      chk($sformatf("dut%0d reset rsp_rdata", d), rdata[d], 32'd0);
      chk($sformatf("dut%0d reset busy", d), 32'(bsy[d]), 32'd0);
    end

    // Back-to-back write then read of the same word, one response per cycle.
    issue(0, 0, 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1, "b2b wr 0x4", a0);
    issue(0, 1, 32'h4, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1, "b2b rd 0x4", a1);
    chk("dut0 b2b accept spacing", 32'(a1), 32'(a0 + 1));

    // Partial writes and the wmask=0 no-op.
    issue(0, 0, 32'h8, 32'h1122_3344, 4'hF, 0, 32'h0, 1, "full wr 0x8", a0);
    issue(0, 0, 32'h8, 32'hAABB_CCDD, 4'h5, 0, 32'h0, 1, "mask5 wr 0x8", a0);
    issue(0, 1, 32'h8, 32'h0, 4'h0, 0, 32'h11BB_33DD, 1, "partial rd 0x8", a0);
    issue(0, 0, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1, "mask0 wr 0x8", a0);
    issue(0, 1, 32'h8, 32'h0, 4'h0, 0, 32'h11BB_33DD, 1, "noop rd 0x8", a0);

    // Range boundary: word 1023 is valid, word 1024 (aliases word 0 if truncated) is not.
    issue(0, 0, 32'h0, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1, "wr 0x0", a0);
    issue(0, 0, 32'hFFC, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 1, "wr 0xffc", a0);
    issue(0, 0, 32'h1000, 32'h1234_5678, 4'hF, 1, 32'h0, 1, "oor wr 0x1000", a0);
    issue(0, 1, 32'h1000, 32'h0, 4'h0, 1, 32'h0, 1, "oor rd 0x1000", a0);
    issue(0, 1, 32'hFFC, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1, "rd 0xffc", a0);
    issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1, "rd 0x0 after oor", a0);
    drain(0, "range");

    // Backpressure: two reads fill OUTS=2, the third waits for the first completion.
    rr[0] = 1'b0;
    issue(0, 1, 32'h4, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0, "bp rd1", a0);
    issue(0, 1, 32'h8, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0, "bp rd2", a1);
    fork
      issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 0, "bp rd3", a2);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("dut0 stall rsp_valid", 32'(rv[0]), 32'd1);
          chk("dut0 stall rsp_rdata", rdata[0], 32'hDEAD_BEEF);
          chk("dut0 stall rsp_err", 32'(rerr[0]), 32'd0);
          chk("dut0 stall cmd_ready", 32'(cr[0]), 32'd0);
        end
        @(posedge clk);
        #1 rr[0] = 1'b1;
        t = cyc;
      end
    join
    chk("dut0 bp rd3 accept cycle", 32'(a2), 32'(t + 1));
    drain(0, "backpressure");

    // Reset with two reads outstanding; a write presented during reset must be ignored.
    rr[0] = 1'b0;
    issue(0, 1, 32'h4, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0, "pre-rst rd1", a0);
    issue(0, 1, 32'h8, 32'h0, 4'h0, 0, 32'h11BB_33DD, 0, "pre-rst rd2", a0);
    rst[0] = 1'b1;
    cv[0] = 1'b1; rd[0] = 1'b0; addr[0] = 32'h4; wdata[0] = 32'h0; wmask[0] = 4'hF;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    cv[0]  = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("dut0 post-rst rsp_valid", 32'(rv[0]), 32'd0);
    chk("dut0 post-rst busy", 32'(bsy[0]), 32'd0);
    chk("dut0 post-rst cmd_ready", 32'(cr[0]), 32'd1);
    chk("dut0 post-rst rsp_rdata", rdata[0], 32'd0);
    rr[0] = 1'b1;
    issue(0, 1, 32'h4, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1, "post-rst rd 0x4", a0);
    issue(0, 1, 32'h8, 32'h0, 4'h0, 0, 32'h11BB_33DD, 1, "post-rst rd 0x8", a0);
    drain(0, "reset");

    // RD_LAT=3, OUTS=4: streaming writes, then four back-to-back reads.
    for (int i = 0; i < 4; i++)
      issue(1, 0, 32'(i * 4), vals[i], 4'hF, 0, 32'h0, 1, "lat3 wr", a0);
    drain(1, "lat3 writes");
    for (int i = 0; i < 4; i++)
      issue(1, 1, 32'(i * 4), 32'h0, 4'h0, 0, vals[i], 1, "lat3 rd", acc4[i]);
    for (int i = 1; i < 4; i++)
      chk($sformatf("dut1 lat3 rd%0d accept cycle", i), 32'(acc4[i]), 32'(acc4[0] + i));
    t = acc4[0];
    wait_cyc(t + 6);
    chk("dut1 busy during 4th rsp", 32'(bsy[1]), 32'd1);
    chk("dut1 rsp_valid during 4th rsp", 32'(rv[1]), 32'd1);
    @(negedge clk);
    chk("dut1 busy after 4th rsp", 32'(bsy[1]), 32'd0);

    // RD_LAT=3, OUTS=4 stalled: four reads fill it, responses drain in order afterwards.
    rr[1] = 1'b0;
    for (int i = 3; i >= 0; i--)
      issue(1, 1, 32'(i * 4), 32'h0, 4'h0, 0, vals[i], 0, "lat3 bp rd", a0);
    @(negedge clk);
    chk("dut1 full cmd_ready", 32'(cr[1]), 32'd0);
    chk("dut1 stall rsp_valid", 32'(rv[1]), 32'd1);
    chk("dut1 stall rsp_rdata", rdata[1], vals[3]);
    @(posedge clk);
    #1 rr[1] = 1'b1;
    drain(1, "lat3 backpressure");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
